serial_slave_port: RTL

- Downstream endpoint of the serial bus master. Deserialises the master's request frames (R/W flag plus address on addr_tx, write data on data_tx) and writes or reads a local byte memory.
- Read data is returned serially on data_rx, qualified by slave_valid.
- slave_ready advertises availability to the master and arbiter.
- Supports single transfers and incrementing-address bursts.

---
 rtl/serial_slave_port.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: deserialises request frames from the master and
// services single or incrementing-burst writes and reads against a local byte memory.
module serial_slave_port #(
  parameter int ADDR_W   = 14,
  parameter int ID_W     = 2,
  parameter int SLAVE_ID = 0,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic valid,
  input  logic addr_tx,
  input  logic data_tx,
  input  logic burst_mode,
  output logic slave_ready,
  output logic slave_valid,
  output logic data_rx,
  output logic wr_done
);

  localparam int LOCAL_W = ADDR_W - ID_W;
  localparam int CNT_W   = $clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0]       LAT_LAST  = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, SKIP} state_t;

  state_t             state;
  logic               rw;
  logic               burst;
  logic               armed;
  logic [CNT_W-1:0]   bit_cnt;
  logic [3:0]         lat_cnt;
  logic [ADDR_W-2:0]  addr_sr;
  logic [DATA_W-2:0]  data_sr;
  logic [DATA_W-2:0]  rd_sr;
  logic [LOCAL_W-1:0] local_addr;
  logic [DATA_W-1:0]  mem [0:(2**LOCAL_W)-1];

  logic [ADDR_W-1:0]  addr_full;
  logic [DATA_W-1:0]  wr_word;
  logic [DATA_W-1:0]  rd_word;
  logic [DATA_W-1:0]  rd_next_word;
  logic [LOCAL_W-1:0] local_next;
  logic               id_match;
  logic               mem_we;

  // The shift registers hold everything but the bit arriving this cycle, so the
  // complete word is available on the edge that captures its last bit.
  assign addr_full    = {addr_tx, addr_sr};
  assign wr_word      = {data_tx, data_sr};
  assign id_match     = (addr_full[ADDR_W-1 -: ID_W] == ID_W'(SLAVE_ID));
  assign local_next   = local_addr + 1'b1;
  assign rd_word      = mem[local_addr];
  assign rd_next_word = mem[local_next];
  assign mem_we       = (state == WDATA) && valid && (bit_cnt == DATA_LAST);

  always_ff @(posedge clock) begin
    if (mem_we) mem[local_addr] <= wr_word;
  end

  // armed blocks a still-high valid from being taken as a new frame until it has been seen low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rw          <= 1'b0;
      burst       <= 1'b0;
      armed       <= 1'b1;
      bit_cnt     <= '0;
      lat_cnt     <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      rd_sr       <= '0;
      local_addr  <= '0;
      slave_ready <= 1'b0;
      slave_valid <= 1'b0;
      data_rx     <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      if (state != IDLE && !valid) begin
        state       <= IDLE;
        armed       <= 1'b1;
        slave_ready <= 1'b1;
        slave_valid <= 1'b0;
        data_rx     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!valid) begin
              armed       <= 1'b1;
              slave_ready <= 1'b1;
            end else if (armed) begin
              rw          <= addr_tx;
              burst       <= burst_mode;
              bit_cnt     <= '0;
              slave_ready <= 1'b0;
              state       <= ADDR;
            end else begin
              slave_ready <= 1'b0;
            end
          end
          ADDR: begin
            addr_sr <= addr_full[ADDR_W-1:1];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt    <= '0;
              lat_cnt    <= '0;
              local_addr <= addr_full[LOCAL_W-1:0];
              if (!id_match) state <= SKIP;
              else if (rw)   state <= RWAIT;
              else           state <= WDATA;
            end
          end
          WDATA: begin
            data_sr <= wr_word[DATA_W-1:1];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              wr_done <= 1'b1;
              if (burst) begin
                local_addr <= local_next;
              end else begin
                state <= IDLE;
                armed <= 1'b0;
              end
            end
          end
          RWAIT: begin
            lat_cnt <= lat_cnt + 1'b1;
            if (lat_cnt == LAT_LAST) begin
              state       <= RDATA;
              slave_valid <= 1'b1;
              data_rx     <= rd_word[0];
              rd_sr       <= rd_word[DATA_W-1:1];
              bit_cnt     <= '0;
            end
          end
          RDATA: begin
            if (bit_cnt == DATA_LAST) begin
              if (burst) begin
                local_addr <= local_next;
                data_rx    <= rd_next_word[0];
                rd_sr      <= rd_next_word[DATA_W-1:1];
                bit_cnt    <= '0;
              end else begin
                state       <= IDLE;
                armed       <= 1'b0;
                slave_valid <= 1'b0;
                data_rx     <= 1'b0;
              end
            end else begin
              data_rx <= rd_sr[0];
              rd_sr   <= {1'b0, rd_sr[DATA_W-2:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          SKIP: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
